// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                the load opcode, forward-select encodings, the control
//                FSM state encoding and the per-operand forward helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // RISC-V I-type load major opcode
    localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;

    // Forward-select encodings
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Control FSM states
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } ctrl_state_t;

    // Forward source for one execute operand. Mem is checked first so it wins
    // on a double match; x0 destinations never forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rsrc,
        input logic [4:0] rd_mem,
        input logic       wren_mem,
        input logic [4:0] rd_wb,
        input logic       wren_wb
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (wren_mem && (rd_mem != 5'd0) && (rd_mem == rsrc)) begin
            sel = FWD_MEM;
        end else if (wren_wb && (rd_wb != 5'd0) && (rd_wb == rsrc)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forward_unit
//  Description : Combinational operand-forward selection for both execute
//                source operands.
//  Ports       : i_rsrc1_exec/i_rsrc2_exec - execute source registers
//                i_rd_mem/i_wren_mem       - memory-stage destination
//                i_rd_wb/i_wren_wb         - writeback-stage destination
//                o_fwd_a/o_fwd_b           - forward selects (00/01 WB/10 Mem)
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rsrc1_exec,
    input  logic [4:0] i_rsrc2_exec,
    input  logic [4:0] i_rd_mem,
    input  logic       i_wren_mem,
    input  logic [4:0] i_rd_wb,
    input  logic       i_wren_wb,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    assign o_fwd_a = fwd_sel(i_rsrc1_exec, i_rd_mem, i_wren_mem, i_rd_wb, i_wren_wb);
    assign o_fwd_b = fwd_sel(i_rsrc2_exec, i_rd_mem, i_wren_mem, i_rd_wb, i_wren_wb);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Produces operand-forward selects
//                and the stall / bubble / flush / freeze controls from a
//                four-state FSM (RUN, LOAD_STALL, MEM_WAIT, FLUSH).
//                Event priority: wait_Mem > branch_taken_Exec > load-use.
//  Ports       : clock, reset            - clock, sync active-high reset
//                *_Dec, *_Exec, *_Mem, *_WB - pipeline stage register info
//                branch_taken_Exec, wait_Mem - redirect / memory-busy events
//                forward_select_A/B      - forward selects
//                stall_Fetch, stall_Dec, bubble_Exec, flush_Dec, freeze_all
//                ctrl_state              - current FSM state (debug)
//  Config      : HAZARD_PERF_CNT_EN adds saturating stall_count/flush_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] Rsrc1_Dec,
    input  logic [4:0] Rsrc2_Dec,
    input  logic       rs1_used_Dec,
    input  logic       rs2_used_Dec,
    input  logic [4:0] Rsrc1_Exec,
    input  logic [4:0] Rsrc2_Exec,
    input  logic [4:0] Rd_Exec,
    input  logic       wrEn_Exec,
    input  logic [6:0] opcode_Exec,
    input  logic [4:0] Rd_Mem,
    input  logic       wrEn_Mem,
    input  logic [4:0] Rd_WB,
    input  logic       wrEn_WB,
    input  logic       branch_taken_Exec,
    input  logic       wait_Mem,
    output logic [1:0] forward_select_A,
    output logic [1:0] forward_select_B,
    output logic       stall_Fetch,
    output logic       stall_Dec,
    output logic       bubble_Exec,
    output logic       flush_Dec,
    output logic       freeze_all,
    output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    logic        r_branch_pend;
    logic        w_branch_pend_next;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic        w_load_use;

    forward_unit u_forward_unit (
        .i_rsrc1_exec (Rsrc1_Exec),
        .i_rsrc2_exec (Rsrc2_Exec),
        .i_rd_mem     (Rd_Mem),
        .i_wren_mem   (wrEn_Mem),
        .i_rd_wb      (Rd_WB),
        .i_wren_wb    (wrEn_WB),
        .o_fwd_a      (w_fwd_a),
        .o_fwd_b      (w_fwd_b)
    );

    assign forward_select_A = reset ? FWD_NONE : w_fwd_a;
    assign forward_select_B = reset ? FWD_NONE : w_fwd_b;
    assign ctrl_state       = r_state;

    // Load in execute whose destination feeds a source the decode stage reads
    assign w_load_use = (opcode_Exec == I_TYPE_LOAD) && wrEn_Exec && (Rd_Exec != 5'd0) &&
                        ((rs1_used_Dec && (Rd_Exec == Rsrc1_Dec)) ||
                         (rs2_used_Dec && (Rd_Exec == Rsrc2_Dec)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_branch_pend <= w_branch_pend_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_branch_pend_next = r_branch_pend;
        stall_Fetch        = 1'b0;
        stall_Dec          = 1'b0;
        bubble_Exec        = 1'b0;
        flush_Dec          = 1'b0;
        freeze_all         = 1'b0;

        if (reset) begin
            w_state_next       = RUN;
            w_branch_pend_next = 1'b0;
        end else if (wait_Mem) begin
            // Everything holds; a redirect arriving now is remembered and
            // applied once memory is ready.
            freeze_all   = 1'b1;
            stall_Fetch  = 1'b1;
            stall_Dec    = 1'b1;
            w_state_next = MEM_WAIT;
            if (branch_taken_Exec) begin
                w_branch_pend_next = 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken_Exec) begin
                        flush_Dec    = 1'b1;
                        bubble_Exec  = 1'b1;
                        w_state_next = FLUSH;
                    end else if (w_load_use) begin
                        stall_Fetch  = 1'b1;
                        stall_Dec    = 1'b1;
                        bubble_Exec  = 1'b1;
                        w_state_next = LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    // The load has moved on; the consumer still seen in
                    // decode must not trigger a second bubble.
                    if (branch_taken_Exec) begin
                        flush_Dec    = 1'b1;
                        bubble_Exec  = 1'b1;
                        w_state_next = FLUSH;
                    end else begin
                        w_state_next = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (r_branch_pend || branch_taken_Exec) begin
                        flush_Dec          = 1'b1;
                        bubble_Exec        = 1'b1;
                        w_branch_pend_next = 1'b0;
                        w_state_next       = FLUSH;
                    end else if (w_load_use) begin
                        stall_Fetch  = 1'b1;
                        stall_Dec    = 1'b1;
                        bubble_Exec  = 1'b1;
                        w_state_next = LOAD_STALL;
                    end else begin
                        w_state_next = RUN;
                    end
                end
                FLUSH: begin
                    // Decode holds a killed instruction; ignore its hazards.
                    w_state_next = RUN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (stall_Dec && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush_Dec && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire
